// File: rtl/square_pipelined.sv
// Fully pipelined unsigned squarer: one shift-add stage per operand bit plus an output register.
// Optional macro SQUARE_PIPELINED_STALL_EN adds an 'enable' input that freezes the whole pipeline.
module square_pipelined #(
  parameter int INPUT_BITS = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
`ifdef SQUARE_PIPELINED_STALL_EN
  input  logic                    enable,
`endif
  input  logic [INPUT_BITS-1:0]   root,
  output logic                    data_valid,
  output logic [2*INPUT_BITS-1:0] square
);

  localparam int OUTPUT_BITS = 2 * INPUT_BITS;

  logic [INPUT_BITS-1:0]  x_q [INPUT_BITS];
  logic [INPUT_BITS-1:0]  x_d [INPUT_BITS];
  logic [OUTPUT_BITS-1:0] p_q [INPUT_BITS];
  logic [OUTPUT_BITS-1:0] p_d [INPUT_BITS];
  logic [INPUT_BITS-1:0]  v_q;
  logic [INPUT_BITS-1:0]  v_d;
  logic [OUTPUT_BITS-1:0] square_q;
  logic                   data_valid_q;
  logic                   advance;

`ifdef SQUARE_PIPELINED_STALL_EN
  assign advance = enable;
`else
  assign advance = 1'b1;
`endif

  assign x_d[0] = root;
  assign v_d[0] = start;
  assign p_d[0] = root[0] ? OUTPUT_BITS'(root) : '0;

  // Stage gi adds the operand weighted by its bit gi to the running partial sum.
  generate
    for (genvar gi = 1; gi < INPUT_BITS; gi++) begin : g_stage
      assign x_d[gi] = x_q[gi-1];
      assign v_d[gi] = v_q[gi-1];
      assign p_d[gi] = p_q[gi-1] +
                       (x_q[gi-1][gi] ? (OUTPUT_BITS'(x_q[gi-1]) << gi) : '0);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < INPUT_BITS; i++) begin
        x_q[i] <= '0;
        p_q[i] <= '0;
      end
      v_q          <= '0;
      square_q     <= '0;
      data_valid_q <= 1'b0;
    end else if (advance) begin
      for (int i = 0; i < INPUT_BITS; i++) begin
        x_q[i] <= x_d[i];
        p_q[i] <= p_d[i];
      end
      v_q          <= v_d;
      square_q     <= p_q[INPUT_BITS-1];
      data_valid_q <= v_q[INPUT_BITS-1];
    end
  end

  assign square     = square_q;
  assign data_valid = data_valid_q;

endmodule

// File: tb/tb_square_pipelined.sv
// Scoreboard bench for square_pipelined: 8-bit and 5-bit instances, expected results queued at issue time.
`timescale 1ns/1ps
module tb_square_pipelined;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        start8, start5;
  logic [7:0]  root8;
  logic [4:0]  root5;
  logic        dv8, dv5;
  logic [15:0] sq8;
  logic [9:0]  sq5;

  always #5 clk = ~clk;

  square_pipelined #(.INPUT_BITS(8)) u_dut8 (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start8),
`ifdef SQUARE_PIPELINED_STALL_EN
    .enable    (enable),
`endif
    .root      (root8),
    .data_valid(dv8),
    .square    (sq8)
  );

  square_pipelined #(.INPUT_BITS(5)) u_dut5 (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start5),
`ifdef SQUARE_PIPELINED_STALL_EN
    .enable    (enable),
`endif
    .root      (root5),
    .data_valid(dv5),
    .square    (sq5)
  );

  typedef struct {
    logic [15:0] sq;
    int          due;
  } exp_t;

  exp_t q8[$];
  exp_t q5[$];
  int   n_vec = 0;
  int   n_fail = 0;
  int   edge_cnt = 0;
  bit   advanced = 1'b0;
  exp_t e8, e5;

  // Count only edges on which the pipeline is allowed to move.
  always @(posedge clk) begin
    advanced = enable;
    if (enable) edge_cnt++;
  end

  always @(negedge clk) begin
    if (reset_n && advanced) begin
      if (dv8) begin
        n_vec++;
        if (q8.size() == 0) begin
          n_fail++;
          $display("FAIL sq8_spurious: data_valid=1 square=%0d at edge %0d, required no valid", sq8, edge_cnt);
        end else begin
          e8 = q8.pop_front();
          if (sq8 !== e8.sq || edge_cnt != e8.due) begin
            n_fail++;
            $display("FAIL sq8_result: square=%0d at edge %0d, required %0d at edge %0d", sq8, edge_cnt, e8.sq, e8.due);
          end else begin
            $display("[sq8] edge %0d square=%0d ok", edge_cnt, sq8);
          end
        end
      end else if (q8.size() > 0 && q8[0].due <= edge_cnt) begin
        n_vec++;
        n_fail++;
        $display("FAIL sq8_missing: data_valid=0 at edge %0d, required square=%0d valid", edge_cnt, q8[0].sq);
        void'(q8.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && advanced) begin
      if (dv5) begin
        n_vec++;
        if (q5.size() == 0) begin
          n_fail++;
          $display("FAIL sq5_spurious: data_valid=1 square=%0d at edge %0d, required no valid", sq5, edge_cnt);
        end else begin
          e5 = q5.pop_front();
          if (16'(sq5) !== e5.sq || edge_cnt != e5.due) begin
            n_fail++;
            $display("FAIL sq5_result: square=%0d at edge %0d, required %0d at edge %0d", sq5, edge_cnt, e5.sq, e5.due);
          end else begin
            $display("[sq5] edge %0d square=%0d ok", edge_cnt, sq5);
          end
        end
      end else if (q5.size() > 0 && q5[0].due <= edge_cnt) begin
        n_vec++;
        n_fail++;
        $display("FAIL sq5_missing: data_valid=0 at edge %0d, required square=%0d valid", edge_cnt, q5[0].sq);
        void'(q5.pop_front());
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end else begin
      $display("[chk] %s = %0d ok", name, act);
    end
  endtask

  // Result of a capture on the next edge is visible after edge_cnt + 1 + INPUT_BITS.
  task automatic issue8(input logic [7:0] r, input logic s, input logic [15:0] req);
    exp_t e;
    @(negedge clk);
    root8  = r;
    start8 = s;
    if (s) begin
      e.sq  = req;
      e.due = edge_cnt + 9;
      q8.push_back(e);
    end
  endtask

  task automatic issue5(input logic [4:0] r, input logic s, input logic [15:0] req);
    exp_t e;
    @(negedge clk);
    root5  = r;
    start5 = s;
    if (s) begin
      e.sq  = req;
      e.due = edge_cnt + 6;
      q5.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    start8 = 1'b0;
    start5 = 1'b0;
  endtask

  task automatic drain(input int limit);
    int k = 0;
    while ((q8.size() != 0 || q5.size() != 0) && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (q8.size() != 0 || q5.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain: %0d/%0d results outstanding after %0d cycles, required 0", q8.size(), q5.size(), limit);
      q8.delete();
      q5.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  logic [7:0]  dir_root [8] = '{8'd0, 8'd255, 8'd128, 8'd1, 8'd10, 8'd200, 8'd170, 8'd85};
  logic [15:0] dir_sq   [8] = '{16'd0, 16'd65025, 16'd16384, 16'd1, 16'd100, 16'd40000, 16'd28900, 16'd7225};
  logic [4:0]  d5_root  [5] = '{5'd31, 5'd17, 5'd0, 5'd1, 5'd16};
  logic [15:0] d5_sq    [5] = '{16'd961, 16'd289, 16'd0, 16'd1, 16'd256};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    enable  = 1'b1;
    start8  = 1'b0;
    start5  = 1'b0;
    root8   = 8'd0;
    root5   = 5'd0;
    repeat (2) @(negedge clk);
    check("reset_dv8", 32'(dv8), 32'd0);
    check("reset_sq8", 32'(sq8), 32'd0);
    check("reset_dv5", 32'(dv5), 32'd0);
    check("reset_sq5", 32'(sq5), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Isolated zero operand.
    issue8(8'd0, 1'b1, 16'd0);
    idle();
    drain(30);

    // Directed values, isolated then back-to-back.
    for (int i = 0; i < 8; i++) begin
      issue8(dir_root[i], 1'b1, dir_sq[i]);
      idle();
    end
    drain(30);
    for (int i = 0; i < 8; i++) issue8(dir_root[i], 1'b1, dir_sq[i]);
    idle();
    drain(30);

    // Operands without start are squared but must never raise data_valid.
    issue8(8'd99, 1'b0, 16'd0);
    issue8(8'd255, 1'b0, 16'd0);
    issue8(8'd3, 1'b1, 16'd9);
    issue8(8'd77, 1'b0, 16'd0);
    idle();
    drain(30);

    // Odd width instance.
    for (int i = 0; i < 5; i++) issue5(d5_root[i], 1'b1, d5_sq[i]);
    idle();
    drain(30);

    // Full sweep with start held high.
    for (int i = 0; i < 256; i++) issue8(8'(i), 1'b1, 16'(i * i));
    idle();
    drain(40);

    // Mid-stream reset discards in-flight operands.
    issue8(8'd10, 1'b1, 16'd100);
    issue8(8'd11, 1'b1, 16'd121);
    issue8(8'd12, 1'b1, 16'd144);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    start8  = 1'b0;
    start5  = 1'b0;
    q8.delete();
    q5.delete();
    #1;
    check("rst_async_dv8", 32'(dv8), 32'd0);
    check("rst_async_sq8", 32'(sq8), 32'd0);
    check("rst_async_sq5", 32'(sq5), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (15) idle();
    issue8(8'd7, 1'b1, 16'd49);
    idle();
    drain(30);

`ifdef SQUARE_PIPELINED_STALL_EN
    begin
      logic [15:0] snap_sq;
      logic        snap_dv;
      issue8(8'd200, 1'b1, 16'd40000);
      idle();
      repeat (2) @(negedge clk);
      enable  = 1'b0;
      snap_sq = sq8;
      snap_dv = dv8;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check("stall_sq8", 32'(sq8), 32'(snap_sq));
        check("stall_dv8", 32'(dv8), 32'(snap_dv));
      end
      @(negedge clk);
      enable = 1'b1;
      drain(30);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
